csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Owns the single read port and single write port of the CSR register file.
- In normal operation it passes ID reads and WB writes straight through.
- On a trap or mret it takes both ports and runs a fixed multi-cycle sequence: save mepc/mcause/mtval, update mstatus, fetch mtvec or mepc.
- It then issues a one-cycle pipeline flush with the redirect PC. It sits between id/wb and csr_reg.

Parameters:
- DATA_W, 32, CSR data width.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- id_csr_addr_i  in  ADDR_W  ID read address.
- id_csr_read_i  in  1  ID read enable.
- id_csr_data_o  out  DATA_W  read data returned to ID.
- csr_addr_o  out  ADDR_W  read address to CSR file.
- csr_read_o  out  1  read enable to CSR file.
- csr_data_i  in  DATA_W  combinational read data from CSR file.
- wb_csr_wen_i  in  1  WB write request.
- wb_csr_addr_i  in  ADDR_W  WB write address.
- wb_csr_data_i  in  DATA_W  WB write data.
- wb_ready_o  out  1  WB write accepted this cycle.
- csr_wen_o  out  1  write enable to CSR file.
- csr_wr_addr_o  out  ADDR_W  write address to CSR file.
- csr_wr_data_o  out  DATA_W  write data to CSR file.
- trap_req_i  in  1  exception/interrupt request; level, held until req_ack_o.
- trap_pc_i  in  DATA_W  PC of the trapping instruction.
- trap_cause_i  in  DATA_W  mcause value; bit31 set means interrupt.
- trap_val_i  in  DATA_W  mtval value.
- mret_req_i  in  1  mret request; level, held until req_ack_o.
- req_ack_o  out  1  one-cycle pulse when a request is accepted.
- busy_o  out  1  sequence in progress; pipeline must stall.
- flush_o  out  1  one-cycle pipeline flush.
- flush_pc_o  out  DATA_W  redirect target, valid while flush_o is high.

Behaviour:
- Fixed CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
- mstatus fields: MIE bit3, MPIE bit7, MPP[12:11].
- Reset: rstn low at a clk edge forces state IDLE and clears all internal registers. All outputs are 0 the following cycle. A reset mid-sequence abandons it; no further CSR writes and no flush.
- IDLE, reads: csr_addr_o/csr_read_o follow id_*; id_csr_data_o = csr_data_i.
- IDLE, writes: csr_wen_o/csr_wr_addr_o/csr_wr_data_o follow wb_*; wb_ready_o = 1.
- IDLE, request acceptance: if trap_req_i, latch pc/cause/val, pulse req_ack_o, next state T_MEPC. Else if mret_req_i, pulse req_ack_o, next state R_MEPC.
  - trap beats mret when both are high; mret stays pending.
  - A WB write in the same cycle as acceptance still completes that cycle.
- Non-IDLE: busy_o = 1, wb_ready_o = 0 (WB must hold its write), id_csr_data_o = 0. Controller drives csr_read_o/csr_addr_o and csr_wen_o.
- Trap sequence, one state per cycle:
  - T_MEPC: write MEPC = trap_pc; read MTVEC, latch.
  - T_MCAUSE: write MCAUSE = trap_cause; read MSTATUS, latch.
  - T_MSTATUS: write MSTATUS = latched value with MPIE←MIE, MIE←0, MPP←2'b11; other bits unchanged.
  - [T_MTVAL]: see optional feature.
  - T_FLUSH: flush_o = 1, flush_pc_o computed from latched mtvec:
    - mtvec[1:0]=00, or =01 with cause bit31 = 0: target = {mtvec[31:2],2'b00}.
    - mtvec[1:0]=01 with cause bit31 = 1: target = base + 4*cause[30:0], low 32 bits, wraps.
  - T_FLUSH → IDLE.
- Mret sequence:
  - R_MEPC: read MEPC, latch.
  - R_RDST: read MSTATUS, latch.
  - R_WRST: write MSTATUS with MIE←MPIE, MPIE←1, MPP←2'b00.
  - R_FLUSH: flush_o = 1, flush_pc_o = {mepc[31:2],2'b00}.
  - R_FLUSH → IDLE.
- Reads and writes to the same CSR never occur in the same state, which avoids the CSR file's write-to-read bypass loop.
- Requests raised while busy are ignored until IDLE; the first acceptance is the cycle after a flush.
- Latency, acceptance edge to flush_o: trap 4 cycles (5 with MTVAL), mret 4 cycles.
- busy_o is high from the cycle after acceptance through the flush cycle inclusive.

Optional Feature:
- CSR_TRAP_MTVAL_EN defined: state T_MTVAL is inserted between T_MSTATUS and T_FLUSH and writes MTVAL = trap_val.
- CSR_TRAP_MTVAL_EN undefined: T_MTVAL does not exist, MTVAL is never written by this block, and trap_val_i is unused.

Test Plan:
- Pass-through: IDLE, WB write 0x300 = 0x0000_0088, then ID read 0x300 → CSR file sees wen with that data, wb_ready_o = 1, id_csr_data_o = 0x0000_0088.
- Direct trap: mtvec = 0x8000_0100, mstatus = 0x0000_0008, trap pc 0x0000_1004, cause 2.
  - Writes in order: mepc = 0x1004, mcause = 2, mstatus = 0x0000_1880.
  - Flush 4 cycles after acceptance with flush_pc_o = 0x8000_0100.
  - busy_o high for 4 cycles.
- Vectored interrupt: mtvec = 0x8000_0101, cause 0x8000_0007 → flush_pc_o = 0x8000_011C.
- Mret: mepc = 0x0000_2002, mstatus = 0x0000_1880 → mstatus written 0x0000_0088, flush_pc_o = 0x0000_2000.
- Contention: trap_req_i and mret_req_i high with a WB write in the same IDLE cycle → WB write completes, trap sequence runs, mret accepted on the cycle after the trap flush.
  - A WB write presented mid-sequence sees wb_ready_o = 0 until IDLE.
- Reset in T_MCAUSE: no mstatus write, no flush, all outputs 0, state IDLE.
  - With CSR_TRAP_MTVAL_EN defined, a normal trap with trap_val 0xDEAD_BEEF writes MTVAL and flush is at cycle 5.

Source files
------------

// File: rtl/csr_trap_seq_if.sv
// CSR trap sequencer bundle: ID read port, WB write port, CSR file ports,
// trap/mret request and flush handshake. slave = sequencer, master = pipeline side.
interface csr_trap_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] id_csr_addr;
  logic              id_csr_read;
  logic [DATA_W-1:0] id_csr_data;

  logic [ADDR_W-1:0] csr_addr;
  logic              csr_read;
  logic [DATA_W-1:0] csr_data;

  logic              wb_csr_wen;
  logic [ADDR_W-1:0] wb_csr_addr;
  logic [DATA_W-1:0] wb_csr_data;
  logic              wb_ready;

  logic              csr_wen;
  logic [ADDR_W-1:0] csr_wr_addr;
  logic [DATA_W-1:0] csr_wr_data;

  logic              trap_req;
  logic [DATA_W-1:0] trap_pc;
  logic [DATA_W-1:0] trap_cause;
  logic [DATA_W-1:0] trap_val;
  logic              mret_req;
  logic              req_ack;
  logic              busy;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;

  modport master (
    output id_csr_addr, id_csr_read,
    output csr_data,
    output wb_csr_wen, wb_csr_addr, wb_csr_data,
    output trap_req, trap_pc, trap_cause, trap_val,
    output mret_req,
    input  id_csr_data,
    input  csr_addr, csr_read,
    input  wb_ready,
    input  csr_wen, csr_wr_addr, csr_wr_data,
    input  req_ack, busy, flush, flush_pc
  );

  modport slave (
    input  id_csr_addr, id_csr_read,
    input  csr_data,
    input  wb_csr_wen, wb_csr_addr, wb_csr_data,
    input  trap_req, trap_pc, trap_cause, trap_val,
    input  mret_req,
    output id_csr_data,
    output csr_addr, csr_read,
    output wb_ready,
    output csr_wen, csr_wr_addr, csr_wr_data,
    output req_ack, busy, flush, flush_pc
  );
endinterface

// File: rtl/csr_trap_seq.sv
// CSR port owner: passes ID/WB traffic through, runs trap/mret save-restore.
// Define CSR_TRAP_MTVAL_EN to add the mtval write state to the trap sequence.
module csr_trap_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input logic           clk,
  input logic           rstn,
  csr_trap_seq_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MTVEC   = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);
`ifdef CSR_TRAP_MTVAL_EN
  localparam logic [ADDR_W-1:0] A_MTVAL   = ADDR_W'(12'h343);
`endif

  typedef enum logic [3:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MSTATUS,
`ifdef CSR_TRAP_MTVAL_EN
    T_MTVAL,
`endif
    T_FLUSH,
    R_MEPC,
    R_RDST,
    R_WRST,
    R_FLUSH
  } state_t;

  state_t state;
  state_t nxt;

  // live is low for the first cycle after reset so every output reads 0
  logic              live;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] cause;
`ifdef CSR_TRAP_MTVAL_EN
  logic [DATA_W-1:0] val;
`endif
  logic [DATA_W-1:0] tgt;
  logic [DATA_W-1:0] ms;

  logic              take_trap;
  logic              lat_tgt;
  logic              lat_ms;
  logic [DATA_W-1:0] ms_trap;
  logic [DATA_W-1:0] ms_mret;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] vec_off;
  logic [DATA_W-1:0] trap_tgt;

  assign take_trap = (state == IDLE) && live && bus.trap_req;
  assign lat_tgt   = (state == T_MEPC) || (state == R_MEPC);
  assign lat_ms    = (state == T_MCAUSE) || (state == R_RDST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc    <= '0;
      cause <= '0;
`ifdef CSR_TRAP_MTVAL_EN
      val   <= '0;
`endif
      tgt   <= '0;
      ms    <= '0;
    end else begin
      if (take_trap) begin
        pc    <= bus.trap_pc;
        cause <= bus.trap_cause;
`ifdef CSR_TRAP_MTVAL_EN
        val   <= bus.trap_val;
`endif
      end
      if (lat_tgt) tgt <= bus.csr_data;
      if (lat_ms)  ms  <= bus.csr_data;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (live && bus.trap_req)      nxt = T_MEPC;
        else if (live && bus.mret_req) nxt = R_MEPC;
      end
      T_MEPC:    nxt = T_MCAUSE;
      T_MCAUSE:  nxt = T_MSTATUS;
`ifdef CSR_TRAP_MTVAL_EN
      T_MSTATUS: nxt = T_MTVAL;
      T_MTVAL:   nxt = T_FLUSH;
`else
      T_MSTATUS: nxt = T_FLUSH;
`endif
      T_FLUSH:   nxt = IDLE;
      R_MEPC:    nxt = R_RDST;
      R_RDST:    nxt = R_WRST;
      R_WRST:    nxt = R_FLUSH;
      R_FLUSH:   nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    ms_trap      = ms;
    ms_trap[7]   = ms[3];
    ms_trap[3]   = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret      = ms;
    ms_mret[3]   = ms[7];
    ms_mret[7]   = 1'b1;
    ms_mret[12:11] = 2'b00;
  end

  // vectored mode only applies to interrupts; other modes fall back to direct
  always_comb begin
    base     = {tgt[DATA_W-1:2], 2'b00};
    vec_off  = {1'b0, cause[DATA_W-2:0]} << 2;
    trap_tgt = base;
    if (tgt[1:0] == 2'b01 && cause[DATA_W-1])
      trap_tgt = base + vec_off;
  end

  always_comb begin
    bus.id_csr_data = '0;
    bus.csr_addr    = '0;
    bus.csr_read    = 1'b0;
    bus.wb_ready    = 1'b0;
    bus.csr_wen     = 1'b0;
    bus.csr_wr_addr = '0;
    bus.csr_wr_data = '0;
    bus.req_ack     = 1'b0;
    bus.busy        = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    unique case (state)
      IDLE: begin
        if (live) begin
          bus.csr_addr    = bus.id_csr_addr;
          bus.csr_read    = bus.id_csr_read;
          bus.id_csr_data = bus.csr_data;
          bus.csr_wen     = bus.wb_csr_wen;
          bus.csr_wr_addr = bus.wb_csr_addr;
          bus.csr_wr_data = bus.wb_csr_data;
          bus.wb_ready    = 1'b1;
          bus.req_ack     = bus.trap_req | bus.mret_req;
        end
      end
      T_MEPC: begin
        bus.busy        = 1'b1;
        bus.csr_wen     = 1'b1;
        bus.csr_wr_addr = A_MEPC;
        bus.csr_wr_data = pc;
        bus.csr_read    = 1'b1;
        bus.csr_addr    = A_MTVEC;
      end
      T_MCAUSE: begin
        bus.busy        = 1'b1;
        bus.csr_wen     = 1'b1;
        bus.csr_wr_addr = A_MCAUSE;
        bus.csr_wr_data = cause;
        bus.csr_read    = 1'b1;
        bus.csr_addr    = A_MSTATUS;
      end
      T_MSTATUS: begin
        bus.busy        = 1'b1;
        bus.csr_wen     = 1'b1;
        bus.csr_wr_addr = A_MSTATUS;
        bus.csr_wr_data = ms_trap;
      end
`ifdef CSR_TRAP_MTVAL_EN
      T_MTVAL: begin
        bus.busy        = 1'b1;
        bus.csr_wen     = 1'b1;
        bus.csr_wr_addr = A_MTVAL;
        bus.csr_wr_data = val;
      end
`endif
      T_FLUSH: begin
        bus.busy     = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = trap_tgt;
      end
      R_MEPC: begin
        bus.busy     = 1'b1;
        bus.csr_read = 1'b1;
        bus.csr_addr = A_MEPC;
      end
      R_RDST: begin
        bus.busy     = 1'b1;
        bus.csr_read = 1'b1;
        bus.csr_addr = A_MSTATUS;
      end
      R_WRST: begin
        bus.busy        = 1'b1;
        bus.csr_wen     = 1'b1;
        bus.csr_wr_addr = A_MSTATUS;
        bus.csr_wr_data = ms_mret;
      end
      R_FLUSH: begin
        bus.busy     = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = {tgt[DATA_W-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq with a CSR file model and write/flush scoreboard.
// Honours CSR_TRAP_MTVAL_EN for the extra mtval write and longer trap latency.
module tb_csr_trap_seq;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

`ifdef CSR_TRAP_MTVAL_EN
  localparam int TLAT = 5;
`else
  localparam int TLAT = 4;
`endif
  localparam int RLAT = 4;

  csr_trap_seq_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  csr_trap_seq #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] fq[$];
  wr_t         w;
  logic [31:0] fp;

  logic [31:0] mem [0:4095];

  assign bus.csr_data = mem[bus.csr_addr];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (bus.csr_wen) begin
      mem[bus.csr_wr_addr] <= bus.csr_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.csr_wen === 1'b1) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_addr", 32'(bus.csr_wr_addr), 32'(w.a));
        chk("wr_data", bus.csr_wr_data, w.d);
      end
    end
    if (bus.flush === 1'b1) begin
      chk("flush_expected", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        fp = fq.pop_front();
        chk("flush_pc", bus.flush_pc, fp);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [11:0] a, input logic [31:0] d);
    bus.wb_csr_wen  = 1'b1;
    bus.wb_csr_addr = a;
    bus.wb_csr_data = d;
    wq.push_back({a, d});
    @(negedge clk);
    chk("wb_ready", 32'(bus.wb_ready), 32'd1);
    tick;
    bus.wb_csr_wen = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int lat);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) tick;
      @(negedge clk);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_wbrdy"}, 32'(bus.wb_ready), 32'd0);
      chk({tag, "_ack"}, 32'(bus.req_ack), 32'd0);
      chk({tag, "_flush"}, 32'(bus.flush), 32'(k == lat));
    end
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] ms, input logic [31:0] tpc);
    wq.push_back({12'h341, pc});
    wq.push_back({12'h342, cause});
    wq.push_back({12'h300, ms});
`ifdef CSR_TRAP_MTVAL_EN
    wq.push_back({12'h343, 32'hDEAD_BEEF});
`endif
    fq.push_back(tpc);
  endtask

  task automatic do_trap(input string tag, input logic [31:0] pc,
                         input logic [31:0] cause, input logic [31:0] ms,
                         input logic [31:0] tpc);
    push_trap(pc, cause, ms, tpc);
    bus.trap_req   = 1'b1;
    bus.trap_pc    = pc;
    bus.trap_cause = cause;
    bus.trap_val   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_ack"}, 32'(bus.req_ack), 32'd1);
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
    tick;
    bus.trap_req = 1'b0;
    run_seq(tag, TLAT);
    tick;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    tick;
  endtask

  initial begin
    bus.id_csr_addr = '0;
    bus.id_csr_read = 1'b0;
    bus.wb_csr_wen  = 1'b0;
    bus.wb_csr_addr = '0;
    bus.wb_csr_data = '0;
    bus.trap_req    = 1'b0;
    bus.trap_pc     = '0;
    bus.trap_cause  = '0;
    bus.trap_val    = '0;
    bus.mret_req    = 1'b0;

    // reset with live-looking inputs: everything must stay quiet
    rstn = 1'b0;
    bus.id_csr_read = 1'b1;
    bus.id_csr_addr = 12'h300;
    bus.wb_csr_wen  = 1'b1;
    bus.wb_csr_addr = 12'h300;
    bus.wb_csr_data = 32'h55;
    bus.trap_req    = 1'b1;
    tick;
    tick;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_ack", 32'(bus.req_ack), 32'd0);
    chk("rst_wbrdy", 32'(bus.wb_ready), 32'd0);
    chk("rst_wen", 32'(bus.csr_wen), 32'd0);
    chk("rst_read", 32'(bus.csr_read), 32'd0);
    chk("rst_iddata", bus.id_csr_data, 32'd0);
    tick;
    bus.id_csr_read = 1'b0;
    bus.wb_csr_wen  = 1'b0;
    bus.trap_req    = 1'b0;
    rstn = 1'b1;
    tick;

    // pass-through
    wb_write(12'h300, 32'h0000_0088);
    bus.id_csr_read = 1'b1;
    bus.id_csr_addr = 12'h300;
    @(negedge clk);
    chk("pt_read", 32'(bus.csr_read), 32'd1);
    chk("pt_addr", 32'(bus.csr_addr), 32'h300);
    chk("pt_data", bus.id_csr_data, 32'h0000_0088);
    tick;
    bus.id_csr_read = 1'b0;

    // direct trap
    wb_write(12'h305, 32'h8000_0100);
    wb_write(12'h300, 32'h0000_0008);
    do_trap("dir", 32'h0000_1004, 32'd2, 32'h0000_1880, 32'h8000_0100);

    // vectored interrupt
    wb_write(12'h305, 32'h8000_0101);
    do_trap("vec", 32'h0000_3000, 32'h8000_0007, 32'h0000_1800,
            32'h8000_011C);

    // mret
    wb_write(12'h341, 32'h0000_2002);
    wb_write(12'h300, 32'h0000_1880);
    wq.push_back({12'h300, 32'h0000_0088});
    fq.push_back(32'h0000_2000);
    bus.mret_req = 1'b1;
    @(negedge clk);
    chk("mret_ack", 32'(bus.req_ack), 32'd1);
    tick;
    bus.mret_req = 1'b0;
    run_seq("mret", RLAT);
    tick;
    @(negedge clk);
    chk("mret_idle", 32'(bus.busy), 32'd0);
    tick;

    // contention: trap + mret + WB write; mtvec 01 with exception is direct
    wq.push_back({12'h340, 32'h1234_5678});
    push_trap(32'h0000_5000, 32'd5, 32'h0000_1880, 32'h8000_0100);
    wq.push_back({12'h340, 32'hCAFE_0000});
    wq.push_back({12'h300, 32'h0000_0088});
    fq.push_back(32'h0000_5000);
    bus.trap_req    = 1'b1;
    bus.trap_pc     = 32'h0000_5000;
    bus.trap_cause  = 32'd5;
    bus.trap_val    = 32'hDEAD_BEEF;
    bus.mret_req    = 1'b1;
    bus.wb_csr_wen  = 1'b1;
    bus.wb_csr_addr = 12'h340;
    bus.wb_csr_data = 32'h1234_5678;
    @(negedge clk);
    chk("ct_ack", 32'(bus.req_ack), 32'd1);
    chk("ct_wbrdy", 32'(bus.wb_ready), 32'd1);
    tick;
    bus.trap_req    = 1'b0;
    bus.wb_csr_data = 32'hCAFE_0000;
    run_seq("ct_trap", TLAT);
    tick;
    @(negedge clk);
    chk("ct_mret_ack", 32'(bus.req_ack), 32'd1);
    chk("ct_wbrdy2", 32'(bus.wb_ready), 32'd1);
    chk("ct_busy", 32'(bus.busy), 32'd0);
    tick;
    bus.mret_req   = 1'b0;
    bus.wb_csr_wen = 1'b0;
    run_seq("ct_mret", RLAT);
    tick;
    @(negedge clk);
    chk("ct_idle", 32'(bus.busy), 32'd0);
    tick;

    // reset while in T_MCAUSE
    wq.push_back({12'h341, 32'h0000_6000});
    wq.push_back({12'h342, 32'd3});
    bus.trap_req   = 1'b1;
    bus.trap_pc    = 32'h0000_6000;
    bus.trap_cause = 32'd3;
    @(negedge clk);
    chk("rm_ack", 32'(bus.req_ack), 32'd1);
    tick;
    bus.trap_req = 1'b0;
    @(negedge clk);
    chk("rm_busy1", 32'(bus.busy), 32'd1);
    tick;
    rstn = 1'b0;
    @(negedge clk);
    chk("rm_busy2", 32'(bus.busy), 32'd1);
    tick;
    rstn = 1'b1;
    @(negedge clk);
    chk("rm_busy", 32'(bus.busy), 32'd0);
    chk("rm_flush", 32'(bus.flush), 32'd0);
    chk("rm_wen", 32'(bus.csr_wen), 32'd0);
    chk("rm_read", 32'(bus.csr_read), 32'd0);
    chk("rm_wbrdy", 32'(bus.wb_ready), 32'd0);
    chk("rm_ack0", 32'(bus.req_ack), 32'd0);
    chk("rm_fpc", bus.flush_pc, 32'd0);
    tick;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rm_quiet_busy", 32'(bus.busy), 32'd0);
      chk("rm_quiet_wbrdy", 32'(bus.wb_ready), 32'd1);
      tick;
    end

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("fq_empty", 32'(fq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
